// File: rtl/td4_ctrl_pkg.sv
// Shared types for the TD4 run controller: panel mode encodings, sequencer states
// and a helper that sizes a counter for a given divisor.
package td4_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_HALT = 2'b00,
      MODE_STEP = 2'b01,
      MODE_SLOW = 2'b10,
      MODE_FAST = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      ST_INIT = 3'd0,
      ST_HALT = 3'd1,
      ST_STEP = 3'd2,
      ST_SLOW = 3'd3,
      ST_FAST = 3'd4
   } state_e;

   // Smallest width (>=1) able to hold the values 0..val-1.
   function automatic int cnt_width(input int unsigned val);
      int w;
      w = 1;
      for (int i = 1; i < 32; i++) begin
         if ((64'd1 << i) < 64'(val)) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/td4_btn_debounce.sv
// Front-panel button conditioning: 2-FF synchroniser, stable-level debounce and a
// one-cycle pulse on each accepted press (active-low line going 1->0).
module td4_btn_debounce
   import td4_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 500_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn_n,
   output logic o_press
);

   localparam int CW = cnt_width(DEBOUNCE_CYC);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_press;
   logic [CW-1:0] r_cnt;

   // Synchronise, then accept a new level only after DEBOUNCE_CYC differing cycles in a row.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_level <= 1'b1;
         r_press <= 1'b0;
         r_cnt   <= {CW{1'b0}};
      end else begin
         r_sync1 <= i_btn_n;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_level) begin
            r_cnt   <= {CW{1'b0}};
            r_press <= 1'b0;
         end else if (r_cnt == LAST) begin
            r_level <= r_sync2;
            r_cnt   <= {CW{1'b0}};
            r_press <= ~r_sync2;
         end else begin
            r_cnt   <= r_cnt + CW'(1);
            r_press <= 1'b0;
         end
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/td4_run_controller.sv
// TD4 execution sequencer: turns three debounced panel buttons into a one-cycle CPU
// clock enable, a CPU reset and a running count of issued enables.
module td4_run_controller
   import td4_ctrl_pkg::*;
#(
   parameter int DIV_SLOW     = 50_000_000,
   parameter int DIV_FAST     = 5_000_000,
   parameter int DEBOUNCE_CYC = 500_000,
   parameter int CPU_RST_CYC  = 16
) (
   input  logic       CLK_I,
   input  logic       RST_I,
   input  logic       BTN_MODE_I,
   input  logic       BTN_STEP_I,
   input  logic       BTN_CPURST_I,
   output logic       TD4_CE_O,
   output logic       TD4_RST_O,
   output logic [1:0] MODE_O,
   output logic [7:0] CE_CNT_O
);

   localparam int PW = cnt_width((DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST);
   localparam int IW = cnt_width(CPU_RST_CYC);
   localparam logic [PW-1:0] SLOW_LAST = PW'(DIV_SLOW - 1);
   localparam logic [PW-1:0] FAST_LAST = PW'(DIV_FAST - 1);
   localparam logic [IW-1:0] INIT_LAST = IW'(CPU_RST_CYC - 1);

   logic w_mode_ev;
   logic w_step_ev;
   logic w_rst_ev;

   state_e        r_state;
   logic [PW-1:0] r_presc;
   logic [IW-1:0] r_init_cnt;
   logic          r_ce;
   logic          r_rst;
   logic [1:0]    r_mode;
   logic [7:0]    r_ce_cnt;

   td4_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
      .i_clk(CLK_I), .i_rst(RST_I), .i_btn_n(BTN_MODE_I), .o_press(w_mode_ev)
   );

   td4_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_step (
      .i_clk(CLK_I), .i_rst(RST_I), .i_btn_n(BTN_STEP_I), .o_press(w_step_ev)
   );

   td4_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_cpurst (
      .i_clk(CLK_I), .i_rst(RST_I), .i_btn_n(BTN_CPURST_I), .o_press(w_rst_ev)
   );

   // Sequencer FSM; CPU-reset press outranks everything, then mode, then step.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         r_state    <= ST_INIT;
         r_presc    <= {PW{1'b0}};
         r_init_cnt <= {IW{1'b0}};
         r_ce       <= 1'b0;
         r_rst      <= 1'b1;
         r_mode     <= MODE_HALT;
         r_ce_cnt   <= 8'd0;
      end else if (w_rst_ev) begin
         r_state    <= ST_INIT;
         r_presc    <= {PW{1'b0}};
         r_init_cnt <= {IW{1'b0}};
         r_ce       <= 1'b0;
         r_rst      <= 1'b1;
         r_mode     <= MODE_HALT;
         r_ce_cnt   <= 8'd0;
      end else begin
         r_ce <= 1'b0;
         case (r_state)
            ST_INIT: begin
               r_ce_cnt <= 8'd0;
               r_mode   <= MODE_HALT;
               r_presc  <= {PW{1'b0}};
               if (r_init_cnt == INIT_LAST) begin
                  r_state    <= ST_HALT;
                  r_rst      <= 1'b0;
                  r_init_cnt <= {IW{1'b0}};
               end else begin
                  r_init_cnt <= r_init_cnt + IW'(1);
               end
            end
            ST_HALT: begin
               if (w_mode_ev) begin
                  r_state <= ST_STEP;
                  r_mode  <= MODE_STEP;
                  r_presc <= {PW{1'b0}};
               end
            end
            ST_STEP: begin
               if (w_mode_ev) begin
                  r_state <= ST_SLOW;
                  r_mode  <= MODE_SLOW;
                  r_presc <= {PW{1'b0}};
               end else if (w_step_ev) begin
                  r_ce     <= 1'b1;
                  r_ce_cnt <= r_ce_cnt + 8'd1;
               end
            end
            ST_SLOW: begin
               if (w_mode_ev) begin
                  r_state <= ST_FAST;
                  r_mode  <= MODE_FAST;
                  r_presc <= {PW{1'b0}};
               end else if (r_presc == SLOW_LAST) begin
                  r_ce     <= 1'b1;
                  r_ce_cnt <= r_ce_cnt + 8'd1;
                  r_presc  <= {PW{1'b0}};
               end else begin
                  r_presc <= r_presc + PW'(1);
               end
            end
            ST_FAST: begin
               if (w_mode_ev) begin
                  r_state <= ST_HALT;
                  r_mode  <= MODE_HALT;
                  r_presc <= {PW{1'b0}};
               end else if (r_presc == FAST_LAST) begin
                  r_ce     <= 1'b1;
                  r_ce_cnt <= r_ce_cnt + 8'd1;
                  r_presc  <= {PW{1'b0}};
               end else begin
                  r_presc <= r_presc + PW'(1);
               end
            end
            default: begin
               r_state    <= ST_INIT;
               r_presc    <= {PW{1'b0}};
               r_init_cnt <= {IW{1'b0}};
               r_rst      <= 1'b1;
               r_mode     <= MODE_HALT;
               r_ce_cnt   <= 8'd0;
            end
         endcase
      end
   end

   assign TD4_CE_O  = r_ce;
   assign TD4_RST_O = r_rst;
   assign MODE_O    = r_mode;
   assign CE_CNT_O  = r_ce_cnt;

endmodule

// File: tb/tb_td4_run_controller.sv
// Directed bench for td4_run_controller with small divisors so every mode is reachable quickly.
module tb_td4_run_controller;

   localparam logic [2:0] B_MODE = 3'b001;
   localparam logic [2:0] B_STEP = 3'b010;
   localparam logic [2:0] B_RST  = 3'b100;

   logic       clk;
   logic       rst;
   logic       btn_mode;
   logic       btn_step;
   logic       btn_cpurst;
   logic       ce;
   logic       cpu_rst;
   logic [1:0] mode;
   logic [7:0] ce_cnt;

   int total;
   int bad;

   td4_run_controller #(
      .DIV_SLOW(20), .DIV_FAST(5), .DEBOUNCE_CYC(4), .CPU_RST_CYC(3)
   ) dut (
      .CLK_I(clk), .RST_I(rst), .BTN_MODE_I(btn_mode), .BTN_STEP_I(btn_step),
      .BTN_CPURST_I(btn_cpurst), .TD4_CE_O(ce), .TD4_RST_O(cpu_rst),
      .MODE_O(mode), .CE_CNT_O(ce_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [2:0] mask, input logic val);
      @(posedge clk);
      #1;
      if (mask[0]) btn_mode = val;
      if (mask[1]) btn_step = val;
      if (mask[2]) btn_cpurst = val;
   endtask

   // Samples n negedges, counting enables and reset cycles and checking CE never overlaps reset.
   task automatic run_count(input int n, output int ces, output int rsts);
      ces = 0;
      rsts = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         total++;
         if (ce && cpu_rst) begin
            bad++;
            $display("FAIL ce_during_rst: ce=%0b rst=%0b required ce=0", ce, cpu_rst);
         end
         if (ce) ces++;
         if (cpu_rst) rsts++;
      end
   endtask

   task automatic press(input logic [2:0] mask, input int low_c, input int tail_c,
                        output int ces, output int rsts);
      int c1, r1, c2, r2;
      drive(mask, 1'b0);
      run_count(low_c, c1, r1);
      drive(mask, 1'b1);
      run_count(tail_c, c2, r2);
      ces = c1 + c2;
      rsts = r1 + r2;
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic test_reset;
      int rsts, ces, mode_nz;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({ce, cpu_rst, mode, ce_cnt} !== {1'b0, 1'b1, 2'b00, 8'd0}) begin
         bad++;
         $display("FAIL reset_values: got ce=%0b rst=%0b mode=%0d cnt=%0d expected 0/1/0/0",
                  ce, cpu_rst, mode, ce_cnt);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      rsts = 0; ces = 0; mode_nz = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (cpu_rst) rsts++;
         if (ce) ces++;
         if (mode != 2'b00) mode_nz++;
      end
      check_int("init_rst_len", rsts, 3);
      check_int("init_no_ce", ces, 0);
      check_int("init_mode_zero", mode_nz, 0);
   endtask

   task automatic test_step;
      int c, r;
      press(B_STEP, 10, 20, c, r);
      check_int("halt_step_ignored", c, 0);
      press(B_MODE, 10, 20, c, r);
      check_int("mode_to_step", int'(mode), 1);
      check_int("mode_press_no_ce", c, 0);
      press(B_STEP, 10, 20, c, r);
      check_int("step_one_ce", c, 1);
      check_int("step_ce_cnt", int'(ce_cnt), 1);
   endtask

   task automatic test_bounce;
      int c, r, ct;
      ct = 0;
      for (int i = 0; i < 2; i++) begin
         drive(B_STEP, 1'b0);
         run_count(1, c, r); ct += c;
         run_count(1, c, r); ct += c;
         drive(B_STEP, 1'b1);
         run_count(1, c, r); ct += c;
         run_count(1, c, r); ct += c;
      end
      press(B_STEP, 10, 20, c, r);
      ct += c;
      check_int("bounce_one_ce", ct, 1);
      check_int("bounce_ce_cnt", int'(ce_cnt), 2);
   endtask

   task automatic test_run_fast;
      int c, r, k, lat, gap, n, bad_gap;
      press(B_MODE, 8, 8, c, r);
      check_int("mode_to_slow", int'(mode), 2);
      check_int("slow_short_no_ce", c, 0);
      drive(B_MODE, 1'b0);
      k = 0;
      while (mode != 2'b11 && k < 40) begin
         @(negedge clk);
         k++;
      end
      check_int("mode_to_fast", int'(mode), 3);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!ce && lat < 30);
      check_int("fast_first_ce_latency", lat, 5);
      drive(B_MODE, 1'b1);
      gap = 0; n = 0; bad_gap = 0;
      for (int i = 0; i < 95; i++) begin
         @(negedge clk);
         gap++;
         if (ce) begin
            n++;
            if (gap != 5) bad_gap++;
            gap = 0;
         end
      end
      check_int("fast_ce_count", n, 19);
      check_int("fast_period_errors", bad_gap, 0);
      check_int("fast_ce_cnt", int'(ce_cnt), 22);
      press(B_MODE, 8, 8, c, r);
      check_int("mode_to_halt", int'(mode), 0);
      run_count(40, c, r);
      check_int("halt_ce_stopped", c, 0);
   endtask

   task automatic test_wrap_cpurst;
      int c, r, k;
      for (int i = 0; i < 3; i++) press(B_MODE, 8, 8, c, r);
      check_int("wrap_mode_fast", int'(mode), 3);
      k = 0;
      while (ce_cnt != 8'd255 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check_int("wrap_reached_255", int'(ce_cnt), 255);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!ce && k < 20);
      check_int("wrap_ce_seen", int'(ce), 1);
      check_int("wrap_to_zero", int'(ce_cnt), 0);
      press(B_RST, 8, 12, c, r);
      check_int("cpurst_len", r, 3);
      check_int("cpurst_cnt_clear", int'(ce_cnt), 0);
      check_int("cpurst_mode_halt", int'(mode), 0);
   endtask

   task automatic test_priority_and_rst;
      int c, r, k;
      press(B_MODE, 8, 8, c, r);
      check_int("prio_pre_step", int'(mode), 1);
      press(B_MODE | B_RST, 8, 12, c, r);
      check_int("prio_rst_len", r, 3);
      check_int("prio_mode_halt", int'(mode), 0);
      run_count(30, c, r);
      check_int("prio_no_ce", c, 0);
      for (int i = 0; i < 3; i++) press(B_MODE, 8, 8, c, r);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!ce && k < 30);
      check_int("midrun_ce_seen", int'(ce), 1);
      #1 rst = 1'b1;
      #1;
      total++;
      if ({ce, cpu_rst, mode, ce_cnt} !== {1'b0, 1'b1, 2'b00, 8'd0}) begin
         bad++;
         $display("FAIL async_reset: got ce=%0b rst=%0b mode=%0d cnt=%0d expected 0/1/0/0",
                  ce, cpu_rst, mode, ce_cnt);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      run_count(12, c, r);
      check_int("rerun_rst_len", r, 3);
      check_int("rerun_no_ce", c, 0);
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      btn_mode = 1'b1;
      btn_step = 1'b1;
      btn_cpurst = 1'b1;
      test_reset();
      test_step();
      test_bounce();
      test_run_fast();
      test_wrap_cpurst();
      test_priority_and_rst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
